// File: rtl/seg_scan_if.sv
// Write-side bus of the multiplexed seven-segment driver: single-digit writes, bulk loads and blink mask.
// The blink_mask member exists only when SEG_BLINK_EN is defined.
interface seg_scan_if #(
  parameter int NUM_DIGITS = 4
) ();
  localparam int AW = $clog2(NUM_DIGITS);

  logic                    wr_en;
  logic [AW-1:0]           wr_addr;
  logic [4:0]              wr_code;
  logic                    wr_dp;
  logic                    load_all;
  logic [5*NUM_DIGITS-1:0] codes_in;
`ifdef SEG_BLINK_EN
  logic [NUM_DIGITS-1:0]   blink_mask;
`endif

  modport master (
    output wr_en, wr_addr, wr_code, wr_dp, load_all, codes_in
`ifdef SEG_BLINK_EN
    , blink_mask
`endif
  );

  modport slave (
    input wr_en, wr_addr, wr_code, wr_dp, load_all, codes_in
`ifdef SEG_BLINK_EN
    , blink_mask
`endif
  );
endinterface

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed N-digit seven-segment driver with an anti-ghosting blank at each slot start.
// Per-digit blinking (blink_mask, BLINK_DIV) is compiled in only when SEG_BLINK_EN is defined.
module seg_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYC   = 16
`ifdef SEG_BLINK_EN
  ,
  parameter int BLINK_DIV   = 64
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  seg_scan_if.slave             bus,
  output logic [NUM_DIGITS-1:0] an_n,
  output logic [7:0]            seg_n,
  output logic                  frame_tick
);
  localparam int AW = $clog2(NUM_DIGITS);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] PRES_LAST  = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] BLANK_END  = PW'(BLANK_CYC);
  localparam logic [AW-1:0] IDX_LAST   = AW'(NUM_DIGITS - 1);
  localparam logic [4:0]    CODE_BLANK = 5'd17;

  // Active-low {a,b,c,d,e,f,g}; unused codes fall back to the "0" pattern.
  function automatic logic [6:0] glyph(input logic [4:0] code);
    logic [6:0] g;
    case (code)
      5'd0:    g = 7'b0000001;
      5'd1:    g = 7'b1001111;
      5'd2:    g = 7'b0010010;
      5'd3:    g = 7'b0000110;
      5'd4:    g = 7'b1001100;
      5'd5:    g = 7'b0100100;
      5'd6:    g = 7'b0100000;
      5'd7:    g = 7'b0001111;
      5'd8:    g = 7'b0000000;
      5'd9:    g = 7'b0000100;
      5'd10:   g = 7'b0001000;
      5'd11:   g = 7'b1100000;
      5'd12:   g = 7'b0110001;
      5'd13:   g = 7'b1000010;
      5'd14:   g = 7'b0110000;
      5'd15:   g = 7'b0111000;
      5'd16:   g = 7'b1111110;
      5'd17:   g = 7'b1111111;
      5'd18:   g = 7'b0000001;
      5'd19:   g = 7'b0011000;
      5'd20:   g = 7'b0110000;
      5'd21:   g = 7'b1101010;
      5'd22:   g = 7'b0110001;
      5'd23:   g = 7'b1110001;
      5'd24:   g = 7'b0100100;
      5'd25:   g = 7'b1000010;
      5'd26:   g = 7'b1100011;
      5'd27:   g = 7'b1111010;
      default: g = 7'b0000001;
    endcase
    return g;
  endfunction

  logic [PW-1:0]         pres_reg, pres_next;
  logic [AW-1:0]         idx_reg, idx_next;
  logic                  frame_tick_reg, frame_tick_next;
  logic [4:0]            code_reg [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] dp_reg;
  logic [NUM_DIGITS-1:0] wr_hit;
  logic [NUM_DIGITS-1:0] slot_sel;
  logic [4:0]            load_code [NUM_DIGITS];
  logic [4:0]            cur_code;
  logic                  cur_dp;
  logic [7:0]            seg_word;
  logic [NUM_DIGITS-1:0] an_reg, an_next;
  logic [7:0]            seg_reg, seg_next;

  // Address decode by equality with each digit index: out-of-range addresses hit nothing.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    assign wr_hit[gi]    = bus.wr_en && (bus.wr_addr == AW'(gi));
    assign slot_sel[gi]  = (idx_reg == AW'(gi));
    assign load_code[gi] = bus.codes_in[5*gi +: 5];
  end

  // Scan counters
  always_comb begin
    pres_next       = pres_reg + PW'(1);
    idx_next        = idx_reg;
    frame_tick_next = 1'b0;
    if (pres_reg == PRES_LAST) begin
      pres_next = '0;
      if (idx_reg == IDX_LAST) begin
        idx_next        = '0;
        frame_tick_next = 1'b1;
      end else begin
        idx_next = idx_reg + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pres_reg       <= '0;
      idx_reg        <= '0;
      frame_tick_reg <= 1'b0;
    end else begin
      pres_reg       <= pres_next;
      idx_reg        <= idx_next;
      frame_tick_reg <= frame_tick_next;
    end
  end

  // Digit storage; a bulk load overrides any concurrent single-digit write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) code_reg[i] <= CODE_BLANK;
      dp_reg <= '0;
    end else if (bus.load_all) begin
      for (int i = 0; i < NUM_DIGITS; i++) code_reg[i] <= load_code[i];
      dp_reg <= '0;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (wr_hit[i]) begin
          code_reg[i] <= bus.wr_code;
          dp_reg[i]   <= bus.wr_dp;
        end
      end
    end
  end

`ifdef SEG_BLINK_EN
  localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_DIV - 1);

  logic [FW-1:0] frame_cnt_reg, frame_cnt_next;
  logic          blink_phase_reg, blink_phase_next;
  logic          cur_blink;

  always_comb begin
    frame_cnt_next   = frame_cnt_reg;
    blink_phase_next = blink_phase_reg;
    if (frame_tick_next) begin
      if (frame_cnt_reg == FRAME_LAST) begin
        frame_cnt_next   = '0;
        blink_phase_next = ~blink_phase_reg;
      end else begin
        frame_cnt_next = frame_cnt_reg + FW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_reg   <= '0;
      blink_phase_reg <= 1'b0;
    end else begin
      frame_cnt_reg   <= frame_cnt_next;
      blink_phase_reg <= blink_phase_next;
    end
  end
`endif

  // One-hot mux of the digit being scanned.
  always_comb begin
    cur_code = CODE_BLANK;
    cur_dp   = 1'b0;
`ifdef SEG_BLINK_EN
    cur_blink = 1'b0;
`endif
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (slot_sel[i]) begin
        cur_code = code_reg[i];
        cur_dp   = dp_reg[i];
`ifdef SEG_BLINK_EN
        cur_blink = bus.blink_mask[i];
`endif
      end
    end
  end

  always_comb begin
    seg_word = {~cur_dp, glyph(cur_code)};
`ifdef SEG_BLINK_EN
    if (blink_phase_reg && cur_blink) seg_word = 8'hFF;
`endif
    an_next  = '1;
    seg_next = 8'hFF;
    if (enable) begin
      seg_next = seg_word;
      // Anodes stay off at the start of each slot so the previous digit's segments can discharge.
      if (pres_reg >= BLANK_END) an_next = ~slot_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an_reg  <= '1;
      seg_reg <= 8'hFF;
    end else begin
      an_reg  <= an_next;
      seg_reg <= seg_next;
    end
  end

  assign an_n       = an_reg;
  assign seg_n      = seg_reg;
  assign frame_tick = frame_tick_reg;
endmodule
